// File: rtl/sccomp_run_ctrl_if.sv
// Core-side monitor bus observed by sccomp_run_ctrl: run gate, PC and data-memory store port.
// The core (or a bench) drives the master side; the run controller only listens.
interface sccomp_run_ctrl_if;
  logic        run_en;
  logic [31:0] pc_in;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output run_en,
    output pc_in,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    input run_en,
    input pc_in,
    input mem_we,
    input mem_addr,
    input mem_wdata
  );
endinterface

// File: rtl/sccomp_run_ctrl.sv
// Run controller for sccomp: sequences core reset, counts run cycles, latches tohost/timeout verdict.
// Optional same-PC halt detection is built only when RUN_CTRL_STALL_DETECT_EN is defined.
module sccomp_run_ctrl #(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned MAX_CYCLES   = 3000,
  parameter int unsigned CW           = 32,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0FFC,
  parameter int unsigned STALL_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rstn,
  sccomp_run_ctrl_if.slave    core,
  output logic                cpu_rstn,
  output logic [2:0]          state,
  output logic [CW-1:0]       cycle_cnt,
  output logic                done,
  output logic                pass,
  output logic [30:0]         fail_code,
  output logic                timeout
);

  localparam logic [2:0] StHold    = 3'd0;
  localparam logic [2:0] StRun     = 3'd1;
  localparam logic [2:0] StPass    = 3'd2;
  localparam logic [2:0] StFail    = 3'd3;
  localparam logic [2:0] StTimeout = 3'd4;

  localparam logic [7:0]    HoldLast = 8'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CntLast  = CW'(MAX_CYCLES - 1);
  localparam logic [30:0]   StallCode = 31'h7FFF_FFFF;

  logic [2:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cpu_rstn_q, cpu_rstn_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [30:0]   code_q, code_d;
  logic          timeout_q, timeout_d;

  logic          mbox_hit;
  logic          stall_hit;
  logic [CW-1:0] cnt_inc;

  assign mbox_hit = core.mem_we && (core.mem_addr == TOHOST_ADDR);
  // Saturate rather than wrap so a stuck run never looks freshly started.
  assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

`ifdef RUN_CTRL_STALL_DETECT_EN
  localparam int unsigned   SW        = $clog2(STALL_CYCLES) + 1;
  localparam logic [SW-1:0] StallLast = SW'(STALL_CYCLES - 1);

  logic [31:0]   pc_prev_q;
  logic [SW-1:0] stall_q, stall_d;

  assign stall_hit = (stall_q == StallLast);

  always_comb begin
    stall_d = stall_q;
    if (state_q == StHold) begin
      stall_d = '0;
    end else if (core.pc_in != pc_prev_q) begin
      stall_d = '0;
    end else if (stall_q != StallLast) begin
      stall_d = stall_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_prev_q <= '0;
      stall_q   <= '0;
    end else begin
      pc_prev_q <= core.pc_in;
      stall_q   <= stall_d;
    end
  end
`else
  localparam int unsigned unused_stall_cycles = STALL_CYCLES;

  logic unused_pc;
  assign unused_pc = ^core.pc_in;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    cpu_rstn_d = cpu_rstn_q;
    done_d     = done_q;
    pass_d     = pass_q;
    code_d     = code_q;
    timeout_d  = timeout_q;

    case (state_q)
      StHold: begin
        cpu_rstn_d = 1'b0;
        if (hold_q == HoldLast) begin
          state_d    = StRun;
          hold_d     = '0;
          cpu_rstn_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      StRun: begin
        if (core.run_en) begin
          cnt_d = cnt_inc;
        end
        // Priority: mailbox store, then PC stall, then cycle limit.
        if (mbox_hit) begin
          done_d     = 1'b1;
          cpu_rstn_d = 1'b0;
          if (core.mem_wdata == 32'd1) begin
            state_d = StPass;
            pass_d  = 1'b1;
          end else begin
            state_d = StFail;
            code_d  = core.mem_wdata[31:1];
          end
        end else if (stall_hit) begin
          state_d    = StFail;
          code_d     = StallCode;
          done_d     = 1'b1;
          cpu_rstn_d = 1'b0;
        end else if (core.run_en && (cnt_q == CntLast)) begin
          state_d    = StTimeout;
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          cpu_rstn_d = 1'b0;
        end
      end

      StPass, StFail, StTimeout: begin
        // Terminal: everything frozen until rstn.
      end

      default: begin
        state_d    = StHold;
        hold_d     = '0;
        cnt_d      = '0;
        cpu_rstn_d = 1'b0;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        code_d     = '0;
        timeout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StHold;
      hold_q     <= '0;
      cnt_q      <= '0;
      cpu_rstn_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      code_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      cpu_rstn_q <= cpu_rstn_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      code_q     <= code_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state     = state_q;
  assign cycle_cnt = cnt_q;
  assign cpu_rstn  = cpu_rstn_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = code_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/sccomp_run_ctrl.md
Name: sccomp_run_ctrl

Overview:
- Synthesisable run-control and result monitor for the single-cycle core (sccomp), for both simulation and FPGA bring-up.
- Sequences the core's reset and counts run cycles.
- Detects end of test from a store to a tohost mailbox address, or from a cycle-limit timeout.
- Latches a pass/fail verdict and fail code; replaces fixed-delay reset/run/stop benches with a parametrised, self-checking controller.

Parameters:
RST_CYCLES, 2, cycles cpu_rstn held low after rstn deasserts (1..255)
MAX_CYCLES, 3000, run cycles before timeout (>=1)
CW, 32, width of cycle_cnt
TOHOST_ADDR, 32'h0000_0FFC, byte address of mailbox store that ends the test
STALL_CYCLES, 8, identical-PC cycles that count as halt (optional feature only, >=2)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
run_en  input  1  1 = cycle counting advances in RUN; 0 = pause counter (core not gated)
pc_in  input  32  core PC (sccomp PC_out)
mem_we  input  1  core data-memory write enable
mem_addr  input  32  core data-memory address (sccomp mem_addr_out)
mem_wdata  input  32  core store data (sccomp mem_data_out)
cpu_rstn  output  1  active-low reset to sccomp
state  output  3  FSM state code
cycle_cnt  output  CW  run cycles elapsed
done  output  1  test finished (any terminal state)
pass  output  1  1 = PASS verdict
fail_code  output  31  tohost payload on FAIL, else 0
timeout  output  1  ended by cycle limit

Behaviour:
- Reset (rstn low, async): state=HOLD(0), cpu_rstn=0, cycle_cnt=0, done=0, pass=0, fail_code=0, timeout=0; internal hold counter=0.
- HOLD(0):
  - cpu_rstn=0; hold counter increments each cycle.
  - On the cycle the counter reaches RST_CYCLES-1, go to RUN; cpu_rstn=1 from the first RUN cycle (registered output, no glitch).
- RUN(1):
  - cycle_cnt increments by 1 each cycle run_en=1; holds when run_en=0.
  - Mailbox hit: mem_we=1 and mem_addr==TOHOST_ADDR (full 32-bit compare). Sampled every RUN cycle regardless of run_en.
    - mem_wdata==1: next state PASS, pass=1.
    - Otherwise: next state FAIL, fail_code=mem_wdata[31:1].
    - mem_wdata==0 counts as FAIL with fail_code 0.
  - Timeout: run_en=1 and cycle_cnt==MAX_CYCLES-1 and no mailbox hit this cycle → TIMEOUT, timeout=1. cycle_cnt ends at MAX_CYCLES.
  - Mailbox hit and timeout in the same cycle: mailbox wins, timeout stays 0.
  - cycle_cnt never wraps: at all-ones it saturates, checked before the MAX_CYCLES compare.
- PASS(2), FAIL(3), TIMEOUT(4):
  - Terminal; done=1 registered on entry.
  - cycle_cnt frozen; all verdict outputs held.
  - cpu_rstn returns to 0 on entry, which halts the core.
  - Further mailbox writes ignored. Only rstn leaves a terminal state.
- Codes 5–7 unused; the FSM returns to HOLD if reached.
- Reset mid-run: async clear of all outputs, then the full HOLD sequence is repeated.
- Latency: mailbox store in cycle N → done/pass/fail_code visible after edge N+1 (one register stage).
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro RUN_CTRL_STALL_DETECT_EN.
- Defined:
  - Comparator tracks pc_in. A counter increments when pc_in equals the previous cycle's pc_in and resets to 0 otherwise.
  - On reaching STALL_CYCLES-1 in RUN with no mailbox hit, go to FAIL with fail_code=31'h7FFF_FFFF. This catches the "j ." self-loop idiom.
  - Priority: mailbox > stall > timeout.
  - Counter cleared in HOLD and by reset.
- Undefined: no comparator logic; a self-loop runs to TIMEOUT.

Test Plan:
1. Reset sequencing: rstn low 3 cycles, released; RST_CYCLES=2 → cpu_rstn=0 for exactly 2 posedges after release, 1 thereafter; state=1.
2. Pass: in RUN at cycle_cnt=40 drive mem_we=1, mem_addr=32'h0FFC, mem_wdata=1 → next edge state=2, done=1, pass=1, fail_code=0; cycle_cnt frozen at 41; cpu_rstn=0.
3. Fail code: store mem_wdata=32'h0000_0007 to 32'h0FFC → state=3, pass=0, fail_code=3. A later store of 1 to 32'h0FFC leaves all outputs unchanged. A store of 1 to 32'h0FF8 earlier is ignored.
4. Timeout with tie: MAX_CYCLES=10, no mailbox → state=4, timeout=1, cycle_cnt=10. Rerun with mailbox value 1 on the cycle cycle_cnt==9 → state=2, timeout=0.
5. Pause and async reset: run_en=0 for 5 cycles holds cycle_cnt. Assert rstn mid-RUN between edges → outputs clear immediately, HOLD sequence repeats.
6. RUN_CTRL_STALL_DETECT_EN defined, STALL_CYCLES=8: hold pc_in=32'h0000_0040 → FAIL, fail_code=31'h7FFF_FFFF. Without the macro, the same stimulus reaches TIMEOUT.
